// File: rtl/imem_responder.sv
// Instruction memory responder for the fetch handshake.
// Serves words from an internal RAM after a programmable latency.
module imem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [DATA_WIDTH-1:0] inst_addr,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_err,
  output logic                  busy,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [3:0]            cnt_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  ld_ok;

  // Full-width range checks; only in-range addresses touch the array.
  assign rd_err_d = (addr_q >= DEPTH_W);
  assign ld_ok    = load_en && (load_addr < DEPTH_W);

  always_comb begin
    rd_data_d = NOP_INST;
    if (!rd_err_d) begin
      rd_data_d = mem_q[addr_q[AW-1:0]];
    end
  end

  // Read above samples pre-edge contents, so a same-edge load stays hidden.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      mem_q[load_addr[AW-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inst_req) begin
            addr_q  <= inst_addr;
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            data_q  <= rd_data_d;
            err_q   <= rd_err_d;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (!inst_req) begin
            valid_q <= 1'b0;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign inst_valid = valid_q;
  assign inst_data  = data_q;
  assign inst_err   = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder at LATENCY 1 and 4.
// Random and directed fetches against a word-array reference model.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req     [2];
  logic [31:0] addr    [2];
  logic        valid   [2];
  logic [31:0] data    [2];
  logic        err     [2];
  logic        busy    [2];
  logic        ld_en   [2];
  logic [31:0] ld_addr [2];
  logic [31:0] ld_data [2];

  int n_chk  = 0;
  int n_fail = 0;

  int          lat [2] = '{1, 4};
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_data [2];
  logic        last_err  [2];

  imem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .inst_req(req[0]), .inst_addr(addr[0]),
    .inst_valid(valid[0]), .inst_data(data[0]),
    .inst_err(err[0]), .busy(busy[0]),
    .load_en(ld_en[0]), .load_addr(ld_addr[0]),
    .load_data(ld_data[0])
  );

  imem_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .inst_req(req[1]), .inst_addr(addr[1]),
    .inst_valid(valid[1]), .inst_data(data[1]),
    .inst_err(err[1]), .busy(busy[1]),
    .load_en(ld_en[1]), .load_addr(ld_addr[1]),
    .load_data(ld_data[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(int d, logic [31:0] a);
    if (a >= 32'd256) return NOP;
    return ref_mem[d][a[7:0]];
  endfunction

  task automatic load(int d, logic [31:0] a, logic [31:0] v);
    @(negedge clk);
    ld_en[d]   = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    @(posedge clk);
    #1;
    ld_en[d] = 1'b0;
    if (a < 32'd256) ref_mem[d][a[7:0]] = v;
  endtask

  // One full transaction: accept, wait, respond, hold req, release.
  task automatic fetch(int d, logic [31:0] a, int hold,
                       bit coll, logic [31:0] cval);
    logic [31:0] ew;
    logic        ee;
    ew = exp_word(d, a);
    ee = (a >= 32'd256);
    @(negedge clk);
    req[d]  = 1'b1;
    addr[d] = a;
    @(posedge clk);
    #1;
    chk1("accept_busy", busy[d], 1'b1);
    chk1("accept_novalid", valid[d], 1'b0);
    for (int k = 1; k <= lat[d]; k++) begin
      @(negedge clk);
      addr[d] = $urandom;
      if (k == lat[d] && coll) begin
        ld_en[d]   = 1'b1;
        ld_addr[d] = a;
        ld_data[d] = cval;
      end
      @(posedge clk);
      #1;
      if (k < lat[d]) begin
        chk1("wait_novalid", valid[d], 1'b0);
        chk1("wait_busy", busy[d], 1'b1);
        chk("wait_data_stable", data[d], last_data[d]);
        chk1("wait_err_stable", err[d], last_err[d]);
      end else begin
        chk1("rise_valid", valid[d], 1'b1);
        chk("rise_data", data[d], ew);
        chk1("rise_err", err[d], ee);
      end
    end
    if (coll) begin
      ld_en[d] = 1'b0;
      if (a < 32'd256) ref_mem[d][a[7:0]] = cval;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk1("held_valid", valid[d], 1'b1);
      chk("held_data", data[d], ew);
    end
    @(negedge clk);
    req[d]  = 1'b0;
    addr[d] = $urandom;
    @(posedge clk);
    #1;
    chk1("fall_valid", valid[d], 1'b0);
    chk1("hold_busy", busy[d], 1'b1);
    chk("hold_data", data[d], ew);
    chk1("hold_err", err[d], ee);
    @(posedge clk);
    #1;
    chk1("idle_busy", busy[d], 1'b0);
    chk1("idle_valid", valid[d], 1'b0);
    chk("idle_data", data[d], ew);
    last_data[d] = ew;
    last_err[d]  = ee;
  endtask

  initial begin
    int          d;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      req[i]       = 1'b0;
      addr[i]      = '0;
      ld_en[i]     = 1'b0;
      ld_addr[i]   = '0;
      ld_data[i]   = '0;
      last_data[i] = '0;
      last_err[i]  = 1'b0;
    end
    #2 rst = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk1("rst_valid", valid[i], 1'b0);
      chk("rst_data", data[i], 32'h0);
      chk1("rst_err", err[i], 1'b0);
      chk1("rst_busy", busy[i], 1'b0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++)
        load(i, 32'(j), $urandom | 32'h1);

    load(0, 32'd2, 32'h00500093);
    fetch(0, 32'd2, 0, 0, '0);
    fetch(1, 32'd1, 0, 0, '0);

    @(negedge clk);
    req[1]  = 1'b1;
    addr[1] = 32'd5;
    @(posedge clk);
    #1;
    chk1("rstw_busy_before", busy[1], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("rstw_valid", valid[1], 1'b0);
    chk("rstw_data", data[1], 32'h0);
    chk1("rstw_busy", busy[1], 1'b0);
    chk("rstw_data_l1", data[0], 32'h0);
    req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_data[0] = '0;
    last_data[1] = '0;
    fetch(1, 32'd0, 0, 0, '0);

    fetch(0, 32'd300, 0, 0, '0);
    fetch(0, 32'd3, 0, 0, '0);
    fetch(1, 32'h00000102, 1, 0, '0);
    fetch(1, 32'h80000002, 0, 0, '0);
    fetch(0, 32'hFFFFFFFF, 0, 0, '0);

    load(0, 32'd260, 32'hDEADBEEF);
    fetch(0, 32'd4, 0, 0, '0);

    fetch(0, 32'd5, 6, 0, '0);
    fetch(1, 32'd6, 6, 0, '0);

    load(0, 32'd0, 32'h11);
    load(0, 32'd1, 32'h22);
    load(0, 32'd2, 32'h33);
    fetch(0, 32'd0, 1, 0, '0);
    fetch(0, 32'd1, 1, 1, 32'hAA);
    fetch(0, 32'd2, 1, 0, '0);
    fetch(0, 32'd1, 0, 0, '0);
    fetch(1, 32'd7, 0, 1, 32'h5A5A0001);
    fetch(1, 32'd7, 0, 0, '0);

    repeat (40) begin
      d = int'($urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0)
        a = 32'd256 + $urandom_range(999, 0);
      else
        a = $urandom_range(15, 0);
      fetch(d, a, int'($urandom_range(3, 0)),
            ($urandom_range(3, 0) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Responder end of the instruction-request handshake driven by the fetch unit. It accepts a word address on inst_req/inst_addr, waits a programmable latency, then returns the instruction word on inst_valid/inst_data from an internal word-addressed memory. A load port lets a bootloader or testbench write program words before or during execution. It serves as the core's instruction memory until a real cache replaces it.

Parameters:
DATA_WIDTH, 32, width of addresses, instruction words and load data
DEPTH, 256, number of words in memory; legal addresses 0..DEPTH-1
LATENCY, 1, cycles from request sampled to inst_valid rising; legal range 1..16, other values illegal
NOP_INST, 32'h00000013, word returned for an out-of-range address

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-low
inst_req  in  1  fetch request; level held by the initiator until it sees inst_valid
inst_addr  in  DATA_WIDTH  word address, sampled when a request is accepted
inst_valid  out  1  response valid, registered
inst_data  out  DATA_WIDTH  instruction word, registered; held stable until the next response
inst_err  out  1  high with inst_valid when the accepted address was >= DEPTH
busy  out  1  high in any state other than IDLE
load_en  in  1  write strobe for the memory load port
load_addr  in  DATA_WIDTH  load word address; writes with load_addr >= DEPTH are ignored
load_data  in  DATA_WIDTH  load word

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, inst_valid=0, inst_data=0, inst_err=0, latency counter=0, busy=0. Memory contents are not reset. Reset has immediate effect at any point, including mid-transaction; a pending response is discarded.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE: on an edge with inst_req=1, latch inst_addr into addr_q, load cnt=LATENCY-1, and go to WAIT.
- WAIT: if cnt!=0, decrement cnt. If cnt==0, read mem[addr_q] (or NOP_INST with err=1 if addr_q>=DEPTH), register it into inst_data/inst_err, set inst_valid=1, and go to RESP.
- Latency: a request sampled at edge E0 gives inst_valid=1 immediately after edge E0+LATENCY.
- RESP: inst_valid stays 1. On an edge where inst_req is sampled 0, clear inst_valid and go to HOLD. While inst_req stays 1, remain in RESP.
- Consequences of RESP: valid is high for at least 2 cycles with the fetch unit, and a lingering request is never re-accepted.
- HOLD: one cycle, then go to IDLE. inst_valid=0. inst_data and inst_err are unchanged.
- inst_data/inst_err stability: they stay unchanged from the rise of valid until the next WAIT->RESP edge. The fetch unit samples data after valid has fallen.
- inst_err clears only when the next response loads.
- inst_addr changes outside the IDLE acceptance edge are ignored.
- Load port: synchronous write of mem[load_addr]<=load_data on each edge with load_en=1. Load is permitted in every state.
- Load vs read collision: a read at the WAIT->RESP edge returns memory contents from before that edge. A load to the same address on that same edge is not visible until the next fetch.
- Addresses are compared full-width against DEPTH; there is no wrap-around. Only the low $clog2(DEPTH) bits index memory after the range check.
- The cnt width covers 0..15.

Test Plan:
- Reset: drive rst low asynchronously mid-cycle during WAIT -> inst_valid, inst_data and busy go to 0 without a clock edge. After release, a request to addr 0 is serviced normally.
- Basic fetch, LATENCY=1: load mem[2]=0x00500093, pulse the fetch-style request for addr 2 -> inst_valid rises 1 cycle after the accepting edge with data 0x00500093 and err=0. Valid falls on the edge after req is sampled low; data is still 0x00500093 afterwards.
- LATENCY=4: request addr 1 at edge E0 -> inst_valid rises at E0+4. busy is high from E0 until HOLD exits.
- Out of range, DEPTH=256: request addr 300 -> inst_data=0x00000013, inst_err=1. A following request to addr 3 clears inst_err.
- Held request: keep inst_req=1 for 6 cycles after valid -> valid stays high throughout, exactly one transaction occurs, valid drops 1 edge after req falls, and data is unchanged.
- Integration with the fetch unit plus a compute responder (branch_flag=0), mem[0..2]=0x11,0x22,0x33 -> inst outputs 0x11, 0x22, 0x33 in order; a load collision on addr 1 at its read edge still returns the old 0x22.
